// File: rtl/gt_usr_clk_rst_ctrl.sv
// TX user-clock MMCM reset sequencer and user-clock-ready qualifier, clocked by the free-running system clock.
// Optional feature: define GT_USR_CLK_LOCK_CNT_EN to add the saturating lock_loss_cnt_o output.
module gt_usr_clk_rst_ctrl #(
    parameter int NUMBER_OF_LANES     = 2,
    parameter int MASTER_LANE_ID      = 0,
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int SETTLE_CYCLES       = 256,
    parameter int MAX_RETRIES         = 7
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic [NUMBER_OF_LANES-1:0] tx_reset_done_i,
    input  logic [NUMBER_OF_LANES-1:0] tx_clk_lock_i,
    output logic [NUMBER_OF_LANES-1:0] tx_mmcm_reset_o,
    output logic [NUMBER_OF_LANES-1:0] usr_clk_ready_o,
    output logic                       fail_o,
    output logic                       lock_lost_o,
`ifdef GT_USR_CLK_LOCK_CNT_EN
    output logic [7:0]                 lock_loss_cnt_o,
`endif
    output logic [2:0]                 state_o
);

    localparam int HOLD_W   = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam int LOCK_W   = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]          RETRY_LAST  = 3'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD      = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_READY     = 3'd5,
        ST_FAIL      = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [2:0]          retry_q, retry_d;
    logic                mmcm_rst_q, mmcm_rst_d;
    logic                ready_q, ready_d;
    logic                fail_q, fail_d;
    logic                lost_q, lost_d;
    logic [1:0]          done_sync_q, lock_sync_q;
    logic                done_s, lock_s;

    // Only the master lane gates sequencing; the other lanes are intentionally ignored.
    logic unused_lanes;
    assign unused_lanes = ^{tx_reset_done_i, tx_clk_lock_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            done_sync_q <= 2'b00;
            lock_sync_q <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments make the two stages shift rather than collapse into one flop.
            done_sync_q <= {done_sync_q[0], tx_reset_done_i[MASTER_LANE_ID]};
            lock_sync_q <= {lock_sync_q[0], tx_clk_lock_i[MASTER_LANE_ID]};
        end
    end

    assign done_s = done_sync_q[1];
    assign lock_s = lock_sync_q[1];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                retry_d = '0;
                if (start_i) state_d = ST_HOLD;
            end
            ST_HOLD:      if (hold_cnt_q == HOLD_LAST) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (done_s) state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_SETTLE;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    retry_d = retry_q + 3'd1;
                    state_d = (retry_q == RETRY_LAST) ? ST_FAIL : ST_HOLD;
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_d = ST_HOLD;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_READY;
                    retry_d = '0;
                end
            end
            ST_READY: begin
                if (!lock_s) begin
                    lost_d  = 1'b1;
                    state_d = ST_HOLD;
                end else if (!done_s) begin
                    state_d = ST_HOLD;
                end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_IDLE;
        endcase

        if (!start_i) begin
            state_d = ST_IDLE;
            retry_d = '0;
            lost_d  = 1'b0;
        end
    end

    // Counters restart on every state entry; each one exits its state at terminal count, so none wraps.
    assign hold_cnt_d   = (state_q == ST_HOLD && state_d == ST_HOLD) ? hold_cnt_q + 1'b1 : '0;
    assign lock_cnt_d   = (state_q == ST_WAIT_LOCK && state_d == ST_WAIT_LOCK) ? lock_cnt_q + 1'b1 : '0;
    assign settle_cnt_d = (state_q == ST_SETTLE && state_d == ST_SETTLE) ? settle_cnt_q + 1'b1 : '0;

    // Outputs are decoded from the next state so they change in the same cycle as state_o.
    assign mmcm_rst_d = !(state_d inside {ST_WAIT_LOCK, ST_SETTLE, ST_READY});
    assign ready_d    = (state_d == ST_READY);
    assign fail_d     = (state_d == ST_FAIL);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            lock_cnt_q   <= '0;
            settle_cnt_q <= '0;
            retry_q      <= '0;
            mmcm_rst_q   <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            retry_q      <= retry_d;
            mmcm_rst_q   <= mmcm_rst_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
            lost_q       <= lost_d;
        end
    end

`ifdef GT_USR_CLK_LOCK_CNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            loss_cnt_q <= 8'd0;
        end else if (lost_q && loss_cnt_q != 8'hFF) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_cnt_o = loss_cnt_q;
`endif

    assign tx_mmcm_reset_o = {NUMBER_OF_LANES{mmcm_rst_q}};
    assign usr_clk_ready_o = {NUMBER_OF_LANES{ready_q}};
    assign fail_o          = fail_q;
    assign lock_lost_o     = lost_q;
    assign state_o         = state_q;

endmodule
